// File: rtl/uart_boot_loader.sv
// Boot-frame receiver that loads instruction memory over the UART and releases the core on success.
// Optional build macro BOOT_TIMEOUT_EN: auto-release after TIMEOUT_CYCLES of silence following reset.
module uart_boot_loader #(
    parameter logic [7:0]  MAGIC     = 8'hA5,
    parameter logic [7:0]  ACK_BYTE  = 8'h06,
    parameter logic [7:0]  NAK_BYTE  = 8'h15,
    parameter logic [15:0] MAX_WORDS = 16'd4096
`ifdef BOOT_TIMEOUT_EN
    ,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd50_000_000
`endif
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_ready,
    input  logic [31:0] rx_data,
    output logic        cpu_read,
    input  logic        tx_ready,
    output logic        uart_fifo_write_en,
    output logic [7:0]  uart_fifo_data,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        cpu_hold,
    output logic        boot_done,
    output logic        boot_error
);

    typedef enum logic [2:0] {IDLE, ADDR, LEN, DATA, CSUM, RESP, DONE} state_t;

    state_t      state, state_next;
    logic        taken;
    logic [1:0]  idx;
    logic [31:0] base;
    logic [7:0]  count_lo;
    logic [15:0] count;
    logic [15:0] word_cnt;
    logic [23:0] word_lo;
    logic [7:0]  csum;
    logic [7:0]  reply;

    logic        rx_state;
    logic        take;
    logic [7:0]  rx_byte;
    logic [15:0] count_full;
    logic        timeout_hit;
    logic        unused_rx_bits;

    assign unused_rx_bits = &{1'b0, rx_data[31:8]};

    // One byte per rx_ready assertion: "taken" masks the late-dropping rx_ready.
    always_comb begin
        rx_byte    = rx_data[7:0];
        rx_state   = (state == IDLE) || (state == ADDR) || (state == LEN) ||
                     (state == DATA) || (state == CSUM);
        take       = rx_ready && !taken && rx_state;
        count_full = {rx_byte, count_lo};
    end

`ifdef BOOT_TIMEOUT_EN
    logic [31:0] idle_cnt;
    logic        armed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt <= 32'd0;
            armed    <= 1'b1;
        end else if (take) begin
            armed <= 1'b0;
        end else if (armed && state == IDLE && idle_cnt != TIMEOUT_CYCLES - 32'd1) begin
            idle_cnt <= idle_cnt + 32'd1;
        end
    end

    assign timeout_hit = armed && !take && (state == IDLE) &&
                         (idle_cnt == TIMEOUT_CYCLES - 32'd1);
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (take && rx_byte == MAGIC) state_next = ADDR;
                else if (timeout_hit)         state_next = DONE;
            end
            ADDR: if (take && idx == 2'd3) state_next = LEN;
            LEN: begin
                if (take && idx == 2'd1) begin
                    if (count_full > MAX_WORDS)  state_next = RESP;
                    else if (count_full == 16'd0) state_next = CSUM;
                    else                          state_next = DATA;
                end
            end
            DATA: begin
                if (take && idx == 2'd3 && word_cnt == count - 16'd1) state_next = CSUM;
            end
            CSUM: if (take) state_next = RESP;
            RESP: begin
                if (tx_ready) state_next = (reply == ACK_BYTE) ? DONE : IDLE;
            end
            DONE:    state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken              <= 1'b0;
            cpu_read           <= 1'b0;
            uart_fifo_write_en <= 1'b0;
            uart_fifo_data     <= 8'd0;
            mem_we             <= 1'b0;
            mem_addr           <= 32'd0;
            mem_wdata          <= 32'd0;
            cpu_hold           <= 1'b1;
            boot_done          <= 1'b0;
            boot_error         <= 1'b0;
            idx                <= 2'd0;
            base               <= 32'd0;
            count_lo           <= 8'd0;
            count              <= 16'd0;
            word_cnt           <= 16'd0;
            word_lo            <= 24'd0;
            csum               <= 8'd0;
            reply              <= 8'd0;
        end else begin
            cpu_read           <= take;
            mem_we             <= 1'b0;
            uart_fifo_write_en <= 1'b0;

            if (take)          taken <= 1'b1;
            else if (!rx_ready) taken <= 1'b0;

            case (state)
                IDLE: begin
                    if (take && rx_byte == MAGIC) begin
                        idx  <= 2'd0;
                        csum <= 8'd0;
                    end else if (timeout_hit) begin
                        cpu_hold  <= 1'b0;
                        boot_done <= 1'b0;
                    end
                end
                ADDR: begin
                    if (take) begin
                        base[{idx, 3'b000} +: 8] <= rx_byte;
                        idx <= idx + 2'd1;
                    end
                end
                LEN: begin
                    if (take) begin
                        if (idx == 2'd0) begin
                            count_lo <= rx_byte;
                            idx      <= 2'd1;
                        end else begin
                            count    <= count_full;
                            idx      <= 2'd0;
                            word_cnt <= 16'd0;
                            if (count_full > MAX_WORDS) reply <= NAK_BYTE;
                        end
                    end
                end
                // Payload bytes arrive little-endian; the 4th byte completes and writes a word.
                DATA: begin
                    if (take) begin
                        csum <= csum ^ rx_byte;
                        idx  <= idx + 2'd1;
                        case (idx)
                            2'd0: word_lo[7:0]   <= rx_byte;
                            2'd1: word_lo[15:8]  <= rx_byte;
                            2'd2: word_lo[23:16] <= rx_byte;
                            default: begin
                                mem_we    <= 1'b1;
                                mem_addr  <= base + {14'd0, word_cnt, 2'b00};
                                mem_wdata <= {rx_byte, word_lo};
                                word_cnt  <= word_cnt + 16'd1;
                            end
                        endcase
                    end
                end
                CSUM: begin
                    if (take) begin
                        reply <= (rx_byte == csum && base[1:0] == 2'b00) ? ACK_BYTE : NAK_BYTE;
                    end
                end
                RESP: begin
                    if (tx_ready) begin
                        uart_fifo_write_en <= 1'b1;
                        uart_fifo_data     <= reply;
                        if (reply == ACK_BYTE) begin
                            boot_done  <= 1'b1;
                            boot_error <= 1'b0;
                        end else begin
                            boot_error <= 1'b1;
                        end
                    end
                end
                DONE:    cpu_hold <= 1'b0;
                default: ;
            endcase
        end
    end

endmodule
